// File: rtl/bulls_cows_if.sv
// -----------------------------------------------------------------------------
// bulls_cows_if
//   Key/answer/score bundle between a game driver and bulls_cows_engine.
//
//   Parameters : NDIG (digits per guess), TW (tries counter width).
//                CW is derived from NDIG and must not be overridden.
//   Signals    : key_valid/key_code/new_game/answer  driver -> engine
//                guess/entry_cnt/strike/ball          engine -> driver
//                result_valid/key_err/busy/win/lose   engine -> driver
//                tries                                engine -> driver
//   Modports   : master = game driver side, slave = engine side.
// -----------------------------------------------------------------------------
interface bulls_cows_if #(
  parameter int NDIG = 4,
  parameter int TW   = 8
);
  localparam int CW = $clog2(NDIG + 1);

  logic              key_valid;
  logic [3:0]        key_code;
  logic              new_game;
  logic [4*NDIG-1:0] answer;

  logic [4*NDIG-1:0] guess;
  logic [CW-1:0]     entry_cnt;
  logic [CW-1:0]     strike;
  logic [CW-1:0]     ball;
  logic              result_valid;
  logic              key_err;
  logic              busy;
  logic              win;
  logic              lose;
  logic [TW-1:0]     tries;

  modport master (
    output key_valid, key_code, new_game, answer,
    input  guess, entry_cnt, strike, ball, result_valid, key_err,
    input  busy, win, lose, tries
  );

  modport slave (
    input  key_valid, key_code, new_game, answer,
    output guess, entry_cnt, strike, ball, result_valid, key_err,
    output busy, win, lose, tries
  );
endinterface

// File: rtl/bulls_cows_engine.sv
// -----------------------------------------------------------------------------
// bulls_cows_engine
//   Parametrised Bulls-and-Cows game core. Collects NDIG decimal digits from a
//   debounced key stream, scores the guess against a latched answer one digit
//   per cycle, counts attempts and declares win/lose.
//
//   Parameters : NDIG (2..8), MAX_TRIES (0 = unlimited), TW (tries width).
//   Ports      : clk_i   system clock
//                rst_ni  synchronous active-low reset
//                bus     bulls_cows_if.slave (keys, answer, score outputs)
//   All outputs are registered.
//
//   Optional feature macro: BULLS_COWS_DUP_REJECT_EN
//     defined   : a digit already present in the current entry is rejected
//                 with key_err, so accepted guesses have distinct digits.
//     undefined : duplicate digits are accepted and scored normally.
// -----------------------------------------------------------------------------
module bulls_cows_engine #(
  parameter int NDIG      = 4,
  parameter int MAX_TRIES = 10,
  parameter int TW        = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  bulls_cows_if.slave  bus
);

  localparam int CW = $clog2(NDIG + 1);

  localparam logic [CW-1:0] NDIG_C   = CW'(NDIG);
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);
  localparam logic [TW-1:0] MAX_T    = TW'(MAX_TRIES);

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  typedef enum logic [2:0] {
    S_ENTRY,
    S_SCORE,
    S_REPORT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t            state_q;
  logic [4*NDIG-1:0] ans_q;
  logic [4*NDIG-1:0] guess_q;
  logic [CW-1:0]     entry_cnt_q;
  logic [CW-1:0]     strike_q;
  logic [CW-1:0]     ball_q;
  logic [CW-1:0]     idx_q;       // guess digit being scored
  logic [CW-1:0]     st_cnt_q;    // running strike count during SCORE
  logic [CW-1:0]     bl_cnt_q;    // running ball count during SCORE
  logic              result_valid_q;
  logic              key_err_q;
  logic              busy_q;
  logic              win_q;
  logic              lose_q;
  logic [TW-1:0]     tries_q;

  // ---------------------------------------------------------------------------
  // Scoring datapath: the current guess digit is compared against every
  // answer digit in parallel. A hit at the same position is a strike; a hit
  // anywhere else is a ball. Strike wins over ball, so each guess digit adds
  // at most one to strike+ball even when the answer has repeated digits.
  // ---------------------------------------------------------------------------
  logic [NDIG-1:0] cur_sel;   // one-hot position of idx_q
  logic [NDIG-1:0] ans_eq;    // answer digit k equals current guess digit
  logic [3:0]      g_dig;
  logic            strike_hit;
  logic            ball_hit;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_cmp
    // digit 0 lives in the most significant nibble
    assign cur_sel[gi] = (idx_q == CW'(gi));
    assign ans_eq[gi]  = (ans_q[4*(NDIG-1-gi) +: 4] == g_dig);
  end

  always_comb begin
    g_dig = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cur_sel[k]) begin
        g_dig = guess_q[4*(NDIG-1-k) +: 4];
      end
    end
  end

  assign strike_hit = |(ans_eq & cur_sel);
  assign ball_hit   = |(ans_eq & ~cur_sel);

  // ---------------------------------------------------------------------------
  // Entry-side helpers
  // ---------------------------------------------------------------------------
  logic is_digit;
  logic entry_full;
  logic dup_hit;

  assign is_digit   = (bus.key_code <= 4'd9);
  assign entry_full = (entry_cnt_q == NDIG_C);

`ifdef BULLS_COWS_DUP_REJECT_EN
  // Entered digits sit in the low entry_cnt nibbles because each new key is
  // shifted in at the bottom.
  always_comb begin
    dup_hit = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if ((CW'(k) < entry_cnt_q) && (guess_q[4*k +: 4] == bus.key_code)) begin
        dup_hit = 1'b1;
      end
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // Tries counter saturates instead of wrapping.
  logic [TW-1:0] tries_inc;
  assign tries_inc = (tries_q == {TW{1'b1}}) ? tries_q : tries_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= S_ENTRY;
      ans_q          <= bus.answer;
      guess_q        <= '0;
      entry_cnt_q    <= '0;
      strike_q       <= '0;
      ball_q         <= '0;
      idx_q          <= '0;
      st_cnt_q       <= '0;
      bl_cnt_q       <= '0;
      result_valid_q <= 1'b0;
      key_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      tries_q        <= '0;
    end else begin
      // single-cycle pulses
      result_valid_q <= 1'b0;
      key_err_q      <= 1'b0;

      if (bus.new_game) begin
        // restart from any state; an in-flight score is simply dropped
        state_q     <= S_ENTRY;
        ans_q       <= bus.answer;
        guess_q     <= '0;
        entry_cnt_q <= '0;
        strike_q    <= '0;
        ball_q      <= '0;
        idx_q       <= '0;
        st_cnt_q    <= '0;
        bl_cnt_q    <= '0;
        busy_q      <= 1'b0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
        tries_q     <= '0;
      end else begin
        case (state_q)
          S_ENTRY: begin
            if (bus.key_valid) begin
              if (is_digit) begin
                if (entry_full || dup_hit) begin
                  key_err_q <= 1'b1;
                end else begin
                  guess_q     <= {guess_q[4*NDIG-5:0], bus.key_code};
                  entry_cnt_q <= entry_cnt_q + 1'b1;
                end
              end else if (bus.key_code == KEY_CLEAR) begin
                guess_q     <= '0;
                entry_cnt_q <= '0;
              end else if (bus.key_code == KEY_ENTER) begin
                if (entry_full) begin
                  state_q  <= S_SCORE;
                  busy_q   <= 1'b1;
                  idx_q    <= '0;
                  st_cnt_q <= '0;
                  bl_cnt_q <= '0;
                end else begin
                  key_err_q <= 1'b1;
                end
              end
              // codes 12..15 fall through and are ignored
            end
          end

          S_SCORE: begin
            if (strike_hit) begin
              st_cnt_q <= st_cnt_q + 1'b1;
            end else if (ball_hit) begin
              bl_cnt_q <= bl_cnt_q + 1'b1;
            end
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= S_REPORT;
            end
          end

          S_REPORT: begin
            strike_q       <= st_cnt_q;
            ball_q         <= bl_cnt_q;
            result_valid_q <= 1'b1;
            tries_q        <= tries_inc;
            guess_q        <= '0;
            entry_cnt_q    <= '0;
            busy_q         <= 1'b0;
            // a full match wins even on the final permitted attempt
            if (st_cnt_q == NDIG_C) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
            end else if ((MAX_TRIES != 0) && (tries_inc == MAX_T)) begin
              state_q <= S_LOSE;
              lose_q  <= 1'b1;
            end else begin
              state_q <= S_ENTRY;
            end
          end

          S_WIN, S_LOSE: begin
            // hold score and tries until new_game or reset
          end

          default: begin
            state_q <= S_ENTRY;
          end
        endcase
      end
    end
  end

  assign bus.guess        = guess_q;
  assign bus.entry_cnt    = entry_cnt_q;
  assign bus.strike       = strike_q;
  assign bus.ball         = ball_q;
  assign bus.result_valid = result_valid_q;
  assign bus.key_err      = key_err_q;
  assign bus.busy         = busy_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;
  assign bus.tries        = tries_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// -----------------------------------------------------------------------------
// tb_bulls_cows_engine
//   Directed game sequences on NDIG=4, MAX_TRIES=3. A game-level model (digit
//   queue, array scoring, fixed result latency) is checked against the DUT on
//   every cycle, and hand-computed literals pin key results.
// -----------------------------------------------------------------------------
module tb_bulls_cows_engine;

  localparam int NDIG      = 4;
  localparam int MAX_TRIES = 3;
  localparam int TW        = 8;

  logic clk;
  logic rst_n;

  bulls_cows_if #(.NDIG(NDIG), .TW(TW)) bus ();

  bulls_cows_engine #(.NDIG(NDIG), .MAX_TRIES(MAX_TRIES), .TW(TW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int rv_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Game-level model
  // ---------------------------------------------------------------------------
  int  m_dig[$];
  int  m_ans[NDIG];
  int  m_strike, m_ball, m_tries, m_pend, m_ps, m_pb;
  bit  m_busy, m_win, m_lose, m_rv, m_kerr, started;

  function automatic void score_guess();
    m_ps = 0;
    m_pb = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (m_dig[i] == m_ans[i]) m_ps++;
      else begin
        for (int j = 0; j < NDIG; j++) begin
          if (j != i && m_dig[i] == m_ans[j]) begin
            m_pb++;
            break;
          end
        end
      end
    end
  endfunction

  function automatic void model_step();
    int c;
    bit dup;
    m_rv   = 0;
    m_kerr = 0;
    if (!rst_n || bus.new_game) begin
      for (int k = 0; k < NDIG; k++) m_ans[k] = int'((bus.answer >> (4*(NDIG-1-k))) & 16'hF);
      m_dig.delete();
      m_strike = 0; m_ball = 0; m_tries = 0; m_pend = 0;
      m_busy = 0; m_win = 0; m_lose = 0;
      started = 1;
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_strike = m_ps;
        m_ball   = m_pb;
        m_rv     = 1;
        if (m_tries < 255) m_tries++;
        m_dig.delete();
        m_busy = 0;
        if (m_ps == NDIG) m_win = 1;
        else if (MAX_TRIES != 0 && m_tries == MAX_TRIES) m_lose = 1;
      end
    end else if (!m_win && !m_lose && bus.key_valid) begin
      c = int'(bus.key_code);
      if (c <= 9) begin
        dup = 0;
`ifdef BULLS_COWS_DUP_REJECT_EN
        foreach (m_dig[k]) if (m_dig[k] == c) dup = 1;
`endif
        if (m_dig.size() == NDIG || dup) m_kerr = 1;
        else m_dig.push_back(c);
      end else if (c == 10) begin
        m_dig.delete();
      end else if (c == 11) begin
        if (m_dig.size() == NDIG) begin
          score_guess();
          m_pend = NDIG + 1;
          m_busy = 1;
        end else m_kerr = 1;
      end
    end
  endfunction

  function automatic logic [31:0] exp_guess();
    logic [31:0] g;
    g = 0;
    foreach (m_dig[k]) g = (g << 4) | 32'(m_dig[k]);
    return g;
  endfunction

  // single compare process: model advances on each edge, DUT checked 1 ns later
  always begin
    @(posedge clk);
    #1;
    model_step();
    if (started) begin
      chk("guess",        32'(bus.guess),        exp_guess());
      chk("entry_cnt",    32'(bus.entry_cnt),    32'(m_dig.size()));
      chk("strike",       32'(bus.strike),       32'(m_strike));
      chk("ball",         32'(bus.ball),         32'(m_ball));
      chk("result_valid", 32'(bus.result_valid), 32'(m_rv));
      chk("key_err",      32'(bus.key_err),      32'(m_kerr));
      chk("busy",         32'(bus.busy),         32'(m_busy));
      chk("win",          32'(bus.win),          32'(m_win));
      chk("lose",         32'(bus.lose),         32'(m_lose));
      chk("tries",        32'(bus.tries),        32'(m_tries));
    end
    if (bus.result_valid === 1'b1) rv_total++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic press(input int code, output bit err);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    @(posedge clk);
    #2;
    err = bus.key_err;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic keys4(input int a, input int b, input int c, input int d);
    bit e;
    press(a, e); press(b, e); press(c, e); press(d, e);
  endtask

  task automatic enter_and_wait(input string name, output int lat);
    lat = -1;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd11;
    @(negedge clk);
    bus.key_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #2;
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(NDIG + 1));
  endtask

  task automatic start_game(input logic [15:0] ans);
    @(negedge clk);
    bus.answer   = ans;
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic result_lit(input string name, input int s, input int b, input int t,
                            input int w, input int l);
    chk({name, "_strike"}, 32'(bus.strike), 32'(s));
    chk({name, "_ball"},   32'(bus.ball),   32'(b));
    chk({name, "_tries"},  32'(bus.tries),  32'(t));
    chk({name, "_win"},    32'(bus.win),    32'(w));
    chk({name, "_lose"},   32'(bus.lose),   32'(l));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rv_before;
    bit e;
    tests = 0; fails = 0; rv_total = 0;
    started = 0;
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.new_game  = 1'b0;
    bus.answer    = 16'h1234;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_guess", 32'(bus.guess), 32'h0);
    chk("rst_tries", 32'(bus.tries), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    $display("[TB] reset done");

    // 1234 against 1234: win on first try
    keys4(1, 2, 3, 4);
    chk("t1_guess", 32'(bus.guess), 32'h1234);
    enter_and_wait("t1", lat);
    result_lit("t1", 4, 0, 1, 1, 0);
    chk("t1_model_strike", 32'(m_strike), 32'd4);
    press(5, e);
    chk("t1_win_key_ignored", 32'(e), 32'd0);
    chk("t1_win_guess_held", 32'(bus.guess), 32'h0);
    $display("[TB] guess 1234 -> strike %0d ball %0d latency %0d", bus.strike, bus.ball, lat);

    // 4321 then 1243
    start_game(16'h1234);
    chk("ng_win_cleared", 32'(bus.win), 32'd0);
    keys4(4, 3, 2, 1);
    enter_and_wait("t2", lat);
    result_lit("t2", 0, 4, 1, 0, 0);
    chk("t2_model_ball", 32'(m_ball), 32'd4);
    $display("[TB] guess 4321 -> strike %0d ball %0d", bus.strike, bus.ball);
    keys4(1, 2, 4, 3);
    enter_and_wait("t3", lat);
    result_lit("t3", 2, 2, 2, 0, 0);
    $display("[TB] guess 1243 -> strike %0d ball %0d", bus.strike, bus.ball);

    // short entry, ignored code, overflow digit
    press(5, e); press(6, e);
    rv_before = rv_total;
    press(11, e);
    chk("short_enter_err", 32'(e), 32'd1);
    repeat (8) @(negedge clk);
    chk("short_enter_no_result", 32'(rv_total), 32'(rv_before));
    press(13, e);
    chk("code13_no_err", 32'(e), 32'd0);
    chk("code13_entry_cnt", 32'(bus.entry_cnt), 32'd2);
    press(10, e);
    chk("clear_no_err", 32'(e), 32'd0);
    keys4(5, 6, 7, 8);
    press(9, e);
    chk("fifth_digit_err", 32'(e), 32'd1);
    chk("fifth_digit_guess", 32'(bus.guess), 32'h5678);
    $display("[TB] overflow digit rejected, guess %h", bus.guess);
    enter_and_wait("t4", lat);
    result_lit("t4", 0, 0, 3, 0, 1);
    press(1, e);
    chk("lose_key_ignored", 32'(e), 32'd0);
    $display("[TB] third miss -> lose %0d tries %0d", bus.lose, bus.tries);

    // new game with a new answer: tries cleared, answer relatched
    start_game(16'h5678);
    chk("ng_tries", 32'(bus.tries), 32'd0);
    chk("ng_lose",  32'(bus.lose),  32'd0);
    keys4(5, 6, 7, 8);
    enter_and_wait("t5", lat);
    result_lit("t5", 4, 0, 1, 1, 0);
    $display("[TB] new answer 5678 matched, win %0d", bus.win);

    // win on the last allowed try
    start_game(16'h1234);
    keys4(5, 6, 7, 8); enter_and_wait("t6a", lat);
    keys4(5, 6, 7, 8); enter_and_wait("t6b", lat);
    keys4(1, 2, 3, 4); enter_and_wait("t6c", lat);
    result_lit("t6c", 4, 0, 3, 1, 0);
    $display("[TB] win on try %0d", bus.tries);

    // new_game during SCORE discards the score
    start_game(16'h1234);
    keys4(5, 6, 7, 8); enter_and_wait("t7", lat);
    keys4(1, 2, 3, 4);
    rv_before = rv_total;
    @(negedge clk); bus.key_valid = 1'b1; bus.key_code = 4'd11;
    @(negedge clk); bus.key_valid = 1'b0;
    @(negedge clk); bus.new_game = 1'b1;
    @(negedge clk); bus.new_game = 1'b0;
    chk("abort_ng_busy", 32'(bus.busy), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_ng_no_result", 32'(rv_total), 32'(rv_before));
    chk("abort_ng_strike", 32'(bus.strike), 32'd0);
    chk("abort_ng_tries", 32'(bus.tries), 32'd0);
    $display("[TB] new_game during score: results %0d", rv_total - rv_before);

    // reset during SCORE discards the score
    keys4(1, 2, 3, 4);
    rv_before = rv_total;
    @(negedge clk); bus.key_valid = 1'b1; bus.key_code = 4'd11;
    @(negedge clk); bus.key_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("abort_rst_busy", 32'(bus.busy), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_rst_no_result", 32'(rv_total), 32'(rv_before));
    chk("abort_rst_entry_cnt", 32'(bus.entry_cnt), 32'd0);
    $display("[TB] reset during score: results %0d", rv_total - rv_before);

    // duplicate digits
    start_game(16'h1234);
`ifdef BULLS_COWS_DUP_REJECT_EN
    press(1, e);
    chk("dup_first_ok", 32'(e), 32'd0);
    press(1, e);
    chk("dup_second_err", 32'(e), 32'd1);
    chk("dup_entry_cnt", 32'(bus.entry_cnt), 32'd1);
    $display("[TB] duplicate digit rejected, entry_cnt %0d", bus.entry_cnt);
`else
    keys4(1, 1, 1, 1);
    chk("dup_entry_cnt", 32'(bus.entry_cnt), 32'd4);
    enter_and_wait("t8", lat);
    result_lit("t8", 1, 3, 1, 0, 0);
    $display("[TB] guess 1111 -> strike %0d ball %0d", bus.strike, bus.ball);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bulls_cows_engine.md
Name: bulls_cows_engine

Overview:
- Parametrised Bulls-and-Cows game core; successor to the fixed 4-digit guess/score path in the keypad top level.
- Collects NDIG decimal digits from a debounced, edge-detected key stream and scores the guess sequentially against a latched answer.
- Tracks attempts and declares win/lose; outputs feed LCD, LED, piezo and step-motor blocks.
- Generalised over digit count and attempt limit; adds clear/enter keys, attempt limit and an explicit game FSM.

Parameters:
- NDIG, 4: digits per guess/answer, 2..8.
- MAX_TRIES, 10: attempts before lose; 0 = unlimited.
- CW, $clog2(NDIG+1): strike/ball count width (derived; do not override).
- TW, 8: tries counter width; MAX_TRIES must be < 2^TW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- key_valid  in  1  one-cycle key pulse (already debounced and edge-detected)
- key_code  in  4  0-9 = digit, 10 = clear, 11 = enter, 12-15 = ignored
- new_game  in  1  single-cycle request to restart the game
- answer  in  4*NDIG  BCD answer; digit 0 in the MS nibble
- guess  out  4*NDIG  entry register; first key in the MS nibble
- entry_cnt  out  CW  number of digits entered
- strike  out  CW  last strike count
- ball  out  CW  last ball count
- result_valid  out  1  one-cycle pulse when strike/ball update
- key_err  out  1  one-cycle pulse when a key is rejected
- busy  out  1  high in SCORE and REPORT
- win  out  1  level; high in WIN
- lose  out  1  level; high in LOSE
- tries  out  TW  completed attempts

Behaviour:
- Reset (rst=0 at posedge): state ENTRY; answer latched; all outputs 0.
- Priority: rst > new_game > key_valid.
- new_game, in any state: latch answer; clear guess, entry_cnt, strike, ball and tries; go to ENTRY next cycle. An in-flight score is discarded.
- States: ENTRY, SCORE, REPORT, WIN, LOSE.
- ENTRY, digit key with entry_cnt < NDIG: guess <= {guess[4*NDIG-5:0], code}; entry_cnt+1.
- ENTRY, digit key with entry_cnt == NDIG: key_err; no change.
- ENTRY, clear: guess = 0; entry_cnt = 0; no error.
- ENTRY, enter with entry_cnt == NDIG: go to SCORE; index i = 0; internal counters = 0.
- ENTRY, enter with entry_cnt < NDIG: key_err; stay in ENTRY.
- ENTRY, codes 12-15: silently ignored.
- SCORE, one digit per cycle, NDIG cycles:
  - strike++ if g[i] == a[i].
  - Else ball++ if g[i] == a[j] for any j != i.
  - Each guess digit adds at most 1 to strike+ball.
  - After i = NDIG-1, go to REPORT.
- REPORT (1 cycle):
  - strike/ball outputs load from the internal counters; result_valid = 1.
  - tries+1, saturating at 2^TW-1.
  - guess and entry_cnt cleared.
  - Next state: WIN if strike == NDIG (wins even on the last allowed try); else LOSE if MAX_TRIES != 0 and new tries == MAX_TRIES; else ENTRY.
- Latency: enter accepted at cycle T -> result_valid at T+NDIG+1.
- key_valid in SCORE, REPORT, WIN or LOSE: ignored; no key_err.
- WIN/LOSE hold strike, ball and tries until new_game or reset.
- Answer digits > 9 are compared as-is with no check. Duplicate answer digits follow the same per-guess-digit rule.

Optional Feature:
- Macro: BULLS_COWS_DUP_REJECT_EN.
- Defined: in ENTRY, a digit already in guess[0..entry_cnt-1] raises key_err and is not stored, so every accepted guess has distinct digits.
- Undefined: duplicate digits are accepted and scored per the SCORE rule.

Test Plan:
- Common setup: NDIG=4, MAX_TRIES=3, answer=16'h1234.
- Keys 1,2,3,4,enter -> result_valid 5 cycles after enter; strike=4, ball=0, tries=1; win=1; following keys ignored.
- Keys 4,3,2,1,enter -> strike=0, ball=4; then keys 1,2,4,3,enter -> strike=2, ball=2, tries=2, state ENTRY.
- Keys 5,6,enter -> key_err pulse, no result_valid; keys clear,5,6,7,8,9 -> 5th digit key_err, guess=16'h5678.
- Three wrong guesses (5678 ×3) -> lose=1 after third REPORT; tries=3; new_game -> tries=0, lose=0, ENTRY, new answer latched.
- new_game or rst=0 asserted during SCORE -> no result_valid; strike/ball=0, ENTRY next cycle.
- With BULLS_COWS_DUP_REJECT_EN: keys 1,1 -> second key_err, entry_cnt=1. Without it: guess 1111 -> strike=1, ball=3.
